// File: rtl/mem_stage.sv
// MEM stage: retires ADD and BR, runs LDW/STW through a req/ack data port,
// stalls upstream while an access is outstanding, and owns the CC register.
module mem_stage #(
    parameter int         TIMEOUT  = 16,
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        stall,
    input  logic [1:0]  op_in,
    input  logic [2:0]  dr_in,
    input  logic [15:0] result_in,
    input  logic [2:0]  cc_in,
    input  logic [15:0] store_data,
    input  logic [2:0]  br_nzp,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [2:0]  wb_dr,
    output logic [15:0] wb_data,
    output logic        br_taken,
    output logic [15:0] br_target,
    output logic [2:0]  cc_out,
    output logic        err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [1:0] OP_BR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [0:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    dr_reg;
    logic [2:0]    cc_reg;

    assign stall  = (state_reg == ST_ACCESS);
    assign cc_out = cc_reg;

    function automatic logic [2:0] nzp_of(input logic [15:0] d);
        if (d[15])
            return 3'b100;
        else if (d == 16'h0000)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            dr_reg    <= '0;
            cc_reg    <= CC_RESET;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_dr     <= '0;
            wb_data   <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
            err       <= 1'b0;
        end else begin
            // Retire strobes are pulses; each retiring op below reasserts them.
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            br_taken <= 1'b0;
            err      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (op_in)
                            OP_ADD: begin
                                wb_valid <= 1'b1;
                                wb_we    <= 1'b1;
                                wb_data  <= result_in;
                                wb_dr    <= dr_in;
                                // A malformed all-zero CC would make every later BR fall through.
                                if ($onehot(cc_in))
                                    cc_reg <= cc_in;
                            end
                            OP_BR: begin
                                wb_valid  <= 1'b1;
                                br_taken  <= |(br_nzp & cc_reg);
                                br_target <= result_in;
                            end
                            default: begin
                                if (result_in[0]) begin
                                    wb_valid <= 1'b1;
                                    err      <= 1'b1;
                                end else begin
                                    state_reg <= ST_ACCESS;
                                    cnt_reg   <= '0;
                                    dr_reg    <= dr_in;
                                    mem_req   <= 1'b1;
                                    mem_addr  <= result_in;
                                    mem_we    <= op_in[0];
                                    mem_wdata <= op_in[0] ? store_data : 16'h0000;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    if (mem_ack) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        mem_req   <= 1'b0;
                        wb_valid  <= 1'b1;
                        if (!mem_we) begin
                            wb_we   <= 1'b1;
                            wb_data <= mem_rdata;
                            wb_dr   <= dr_reg;
                            cc_reg  <= nzp_of(mem_rdata);
                        end
                    end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        // Final ACCESS cycle without an ack: abort and report.
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        mem_req   <= 1'b0;
                        wb_valid  <= 1'b1;
                        err       <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected retire events into a
// queue, and a monitor pops and compares each WB_VALID pulse.
module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic [1:0]  op_in;
    logic [2:0]  dr_in;
    logic [15:0] result_in;
    logic [2:0]  cc_in;
    logic [15:0] store_data;
    logic [2:0]  br_nzp;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        br_taken;
    logic [15:0] br_target;
    logic [2:0]  cc_out;
    logic        err;

    mem_stage #(.TIMEOUT(16), .CC_RESET(3'b010)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .op_in(op_in), .dr_in(dr_in), .result_in(result_in), .cc_in(cc_in),
        .store_data(store_data), .br_nzp(br_nzp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dr(wb_dr), .wb_data(wb_data),
        .br_taken(br_taken), .br_target(br_target), .cc_out(cc_out), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  tag;
        logic        we;
        logic [2:0]  dr;
        logic [15:0] data;
        logic        chk_br;
        logic        bt;
        logic [15:0] tgt;
        logic        er;
        logic [2:0]  cc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] tag, input logic we, input logic [2:0] dr,
                                input logic [15:0] data, input logic chk_br, input logic bt,
                                input logic [15:0] tgt, input logic er, input logic [2:0] cc);
        exp_t e;
        e.tag = tag; e.we = we; e.dr = dr; e.data = data; e.chk_br = chk_br;
        e.bt = bt; e.tgt = tgt; e.er = er; e.cc = cc;
        return e;
    endfunction

    // Monitor: one line per retired transaction.
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_retire: got wb_valid=1 expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                $display("retire tag=%0d we=%b dr=%0d data=%h bt=%b tgt=%h err=%b cc=%b",
                         e.tag, wb_we, wb_dr, wb_data, br_taken, br_target, err, cc_out);
                check("wb_we", 16'(wb_we), 16'(e.we));
                if (e.we) begin
                    check("wb_dr", 16'(wb_dr), 16'(e.dr));
                    check("wb_data", wb_data, e.data);
                end
                check("br_taken", 16'(br_taken), 16'(e.bt));
                if (e.chk_br)
                    check("br_target", br_target, e.tgt);
                check("err", 16'(err), 16'(e.er));
                check("cc_out", 16'(cc_out), 16'(e.cc));
            end
        end else if (br_taken || err) begin
            n_cmp++;
            n_fail++;
            $display("FAIL orphan_pulse: got br_taken=%b err=%b with wb_valid=0", br_taken, err);
        end
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] dr, input logic [15:0] res,
                         input logic [2:0] cc, input logic [15:0] sd, input logic [2:0] nzp);
        in_valid = 1'b1; op_in = op; dr_in = dr; result_in = res;
        cc_in = cc; store_data = sd; br_nzp = nzp;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; op_in = '0; dr_in = '0; result_in = '0;
        cc_in = 3'b010; store_data = '0; br_nzp = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cc_out", 16'(cc_out), 16'h0002);
        check("rst_mem_req", 16'(mem_req), 16'h0000);
        check("rst_stall", 16'(stall), 16'h0000);
        check("rst_wb_valid", 16'(wb_valid), 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD then branches against CC=N
        exp_q.push_back(mk(1, 1, 3'd3, 16'hFFFE, 0, 0, 0, 0, 3'b100));
        issue(2'b01, 3'd3, 16'hFFFE, 3'b100, 0, 0);
        exp_q.push_back(mk(2, 0, 0, 0, 1, 1, 16'h0040, 0, 3'b100));
        issue(2'b00, 3'd0, 16'h0040, 3'b010, 0, 3'b100);
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 3'b100));
        issue(2'b00, 3'd0, 16'h0080, 3'b010, 0, 3'b011);

        // LDW 0x0010, ack in the third ACCESS cycle, data 0
        exp_q.push_back(mk(4, 1, 3'd5, 16'h0000, 0, 0, 0, 0, 3'b010));
        issue(2'b10, 3'd5, 16'h0010, 3'b001, 16'h1234, 0);
        for (int k = 1; k <= 3; k++) begin
            check("ldw_stall", 16'(stall), 16'h0001);
            check("ldw_req", 16'(mem_req), 16'h0001);
            check("ldw_addr", mem_addr, 16'h0010);
            check("ldw_we", 16'(mem_we), 16'h0000);
            if (k == 3) begin
                mem_ack = 1'b1; mem_rdata = 16'h0000;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("ldw_done_stall", 16'(stall), 16'h0000);
        check("ldw_done_req", 16'(mem_req), 16'h0000);

        // STW 0x0020 <- BEEF, acked immediately
        exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 3'b010));
        issue(2'b11, 3'd6, 16'h0020, 3'b100, 16'hBEEF, 0);
        check("stw_req", 16'(mem_req), 16'h0001);
        check("stw_we", 16'(mem_we), 16'h0001);
        check("stw_wdata", mem_wdata, 16'hBEEF);
        check("stw_addr", mem_addr, 16'h0020);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;

        // Misaligned LDW
        exp_q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 1, 3'b010));
        issue(2'b10, 3'd1, 16'h0011, 3'b001, 0, 0);
        check("misalign_req", 16'(mem_req), 16'h0000);
        check("misalign_stall", 16'(stall), 16'h0000);

        // Negative LDW followed back-to-back by an ADD
        exp_q.push_back(mk(7, 1, 3'd2, 16'h8001, 0, 0, 0, 0, 3'b100));
        issue(2'b10, 3'd2, 16'h0030, 3'b001, 0, 0);
        mem_ack = 1'b1; mem_rdata = 16'h8001;
        @(negedge clk);
        mem_ack = 1'b0;
        check("b2b_stall", 16'(stall), 16'h0000);
        exp_q.push_back(mk(8, 1, 3'd1, 16'h0005, 0, 0, 0, 0, 3'b001));
        issue(2'b01, 3'd1, 16'h0005, 3'b001, 0, 0);

        // Stray ack in IDLE must not retire anything
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);

        // Timeout: no ack ever
        exp_q.push_back(mk(9, 0, 0, 0, 0, 0, 0, 1, 3'b001));
        issue(2'b10, 3'd4, 16'h0040, 3'b010, 0, 0);
        n = 0;
        while (stall && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", 16'(n), 16'd16);
        check("timeout_req", 16'(mem_req), 16'h0000);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);

        // Reset in the middle of an access
        issue(2'b10, 3'd7, 16'h0050, 3'b010, 0, 0);
        @(negedge clk);
        check("mid_req_before", 16'(mem_req), 16'h0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 16'(mem_req), 16'h0000);
        check("mid_rst_stall", 16'(stall), 16'h0000);
        check("mid_rst_cc", 16'(cc_out), 16'h0002);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
